logic_addr_loader: RTL and testbench



---
 rtl/logic_addr_loader.sv | 144 ++++++++++++++
 tb/tb_logic_addr_loader.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_addr_loader.sv
// Decodes SYNC/ADDR/DATA/CHK frames from a byte stream and issues one table write per good frame.
// Malformed, out-of-range and stalled frames are dropped with an error pulse and code.
module logic_addr_loader #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned NUM_REGS    = 9,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] l_addr,
  output logic       l_wren,
  output logic [7:0] l_data,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] good_cnt
);

  typedef enum logic [2:0] {StIdle, StGetAddr, StGetData, StGetChk, StWrite} state_e;

  localparam logic [1:0]       ErrChk      = 2'b01;
  localparam logic [1:0]       ErrAddr     = 2'b10;
  localparam logic [1:0]       ErrTimeout  = 2'b11;
  localparam logic [7:0]       NumRegsB    = 8'(NUM_REGS);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [3:0]       l_addr_q, l_addr_d;
  logic [7:0]       l_data_q, l_data_d;
  logic [7:0]       good_q, good_d;

  logic addr_bad, chk_ok, in_frame;

  assign addr_bad = (addr_q[7:4] != 4'h0) || (addr_q >= NumRegsB);
  assign chk_ok   = (rx_data == (SYNC_BYTE ^ addr_q ^ data_q));
  assign in_frame = (state_q == StGetAddr) || (state_q == StGetData) || (state_q == StGetChk);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    code_d   = 2'b00;
    l_addr_d = l_addr_q;
    l_data_d = l_data_q;
    good_d   = good_q;

    unique case (state_q)
      // WRITE lasts one cycle and accepts a new header, so back-to-back frames lose nothing.
      StIdle, StWrite: begin
        cnt_d   = '0;
        state_d = StIdle;
        if (rx_valid && (rx_data == SYNC_BYTE)) state_d = StGetAddr;
      end
      StGetAddr: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          state_d = StGetData;
        end
      end
      StGetData: begin
        if (rx_valid) begin
          data_d  = rx_data;
          state_d = StGetChk;
        end
      end
      StGetChk: begin
        if (rx_valid) begin
          if (!chk_ok) begin
            err_d   = 1'b1;
            code_d  = ErrChk;
            state_d = StIdle;
          end else if (addr_bad) begin
            err_d   = 1'b1;
            code_d  = ErrAddr;
            state_d = StIdle;
          end else begin
            l_addr_d = addr_q[3:0];
            l_data_d = data_q;
            good_d   = good_q + 8'd1;
            state_d  = StWrite;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // An arriving byte always beats a timeout that would fire in the same cycle.
    if (in_frame) begin
      if (rx_valid) begin
        cnt_d = '0;
      end else if (cnt_q == TimeoutLast) begin
        cnt_d   = '0;
        err_d   = 1'b1;
        code_d  = ErrTimeout;
        state_d = StIdle;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
      l_addr_q <= '0;
      l_data_q <= '0;
      good_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      code_q   <= code_d;
      l_addr_q <= l_addr_d;
      l_data_q <= l_data_d;
      good_q   <= good_d;
    end
  end

  assign l_wren   = (state_q == StWrite);
  assign busy     = (state_q != StIdle);
  assign err      = err_q;
  assign err_code = code_q;
  assign l_addr   = l_addr_q;
  assign l_data   = l_data_q;
  assign good_cnt = good_q;

endmodule

// File: tb/tb_logic_addr_loader.sv
// Bench for logic_addr_loader: directed scenarios plus random frames, all checked each cycle
// against a frame-level reference model (byte queue + idle counter).
module tb_logic_addr_loader;

  localparam int TO = 1000;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] l_addr;
  logic       l_wren;
  logic [7:0] l_data;
  logic       busy;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] good_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] fr[$];
  int         idle = 0;
  logic       m_wren = 1'b0, m_err = 1'b0, m_busy = 1'b0;
  logic [1:0] m_code = 2'b00;
  logic [3:0] m_addr = 4'h0;
  logic [7:0] m_data = 8'h00, m_cnt = 8'h00;

  logic_addr_loader #(
    .SYNC_BYTE  (8'hA5),
    .NUM_REGS   (9),
    .TIMEOUT_CYC(TO),
    .CNT_W      (16)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .l_addr  (l_addr),
    .l_wren  (l_wren),
    .l_data  (l_data),
    .busy    (busy),
    .err     (err),
    .err_code(err_code),
    .good_cnt(good_cnt)
  );

  always #5 clk = ~clk;

  // Expected outputs after the coming clock edge, from the frame rules alone.
  task automatic model_step(input logic v, input logic [7:0] d);
    m_wren = 1'b0;
    m_err  = 1'b0;
    m_code = 2'b00;
    if (!rstn) begin
      fr.delete();
      idle   = 0;
      m_addr = 4'h0;
      m_data = 8'h00;
      m_cnt  = 8'h00;
    end else if (fr.size() == 0) begin
      if (v && d == 8'hA5) fr.push_back(d);
      idle = 0;
    end else if (v) begin
      fr.push_back(d);
      idle = 0;
      if (fr.size() == 4) begin
        if (fr[3] != (fr[0] ^ fr[1] ^ fr[2])) begin
          m_err = 1'b1; m_code = 2'b01;
        end else if (int'(fr[1]) >= 9) begin
          m_err = 1'b1; m_code = 2'b10;
        end else begin
          m_wren = 1'b1;
          m_addr = fr[1][3:0];
          m_data = fr[2];
          m_cnt  = m_cnt + 8'd1;
        end
        fr.delete();
      end
    end else if (idle == TO - 1) begin
      m_err  = 1'b1;
      m_code = 2'b11;
      fr.delete();
      idle   = 0;
    end else begin
      idle++;
    end
    m_busy = rstn && ((fr.size() > 0) || m_wren);
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    model_step(v, d);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(1'b0, 8'h00);
    drive(1'b1, 8'hA5);
    checks++;
    if ({l_wren, err, err_code, busy, l_addr, l_data, good_cnt} !== 25'd0) begin
      errors++;
      $display("FAIL reset_zero: got %h expected 0",
               {l_wren, err, err_code, busy, l_addr, l_data, good_cnt});
    end
    rstn = 1'b1;
    drive(1'b0, 8'h00);
    checks++;
    if ({busy, err, l_wren} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: got %b expected 000", {busy, err, l_wren});
    end
  endtask

  task automatic test_good_frame();
    logic [8:0] s[$] = '{9'h1A5, 9'h103, 9'h155, 9'h1F3, 9'h000, 9'h000};
    foreach (s[i]) begin
      drive(s[i][8], s[i][7:0]);
      checks++;
      if ({l_wren, err, err_code, busy, l_addr, l_data, good_cnt} !==
          {m_wren, m_err, m_code, m_busy, m_addr, m_data, m_cnt}) begin
        errors++;
        $display("FAIL good_frame model @%0d: got %h expected %h", i,
                 {l_wren, err, err_code, busy, l_addr, l_data, good_cnt},
                 {m_wren, m_err, m_code, m_busy, m_addr, m_data, m_cnt});
      end
      if (i == 3) begin
        checks++;
        if ({l_wren, err, l_addr, l_data, good_cnt} !== {1'b1, 1'b0, 4'h3, 8'h55, 8'd1}) begin
          errors++;
          $display("FAIL good_frame write: got %h expected %h",
                   {l_wren, err, l_addr, l_data, good_cnt}, {1'b1, 1'b0, 4'h3, 8'h55, 8'd1});
        end
      end
      if (i == 4) begin
        checks++;
        if (l_wren !== 1'b0) begin
          errors++;
          $display("FAIL good_frame pulse_width: got %b expected 0", l_wren);
        end
      end
    end
  endtask

  task automatic test_bad_checksum();
    logic [8:0] s[$] = '{9'h1A5, 9'h103, 9'h155, 9'h100, 9'h000, 9'h000};
    foreach (s[i]) begin
      drive(s[i][8], s[i][7:0]);
      checks++;
      if ({l_wren, err, err_code, busy, l_addr, l_data, good_cnt} !==
          {m_wren, m_err, m_code, m_busy, m_addr, m_data, m_cnt}) begin
        errors++;
        $display("FAIL bad_checksum model @%0d: got %h expected %h", i,
                 {l_wren, err, err_code, busy, l_addr, l_data, good_cnt},
                 {m_wren, m_err, m_code, m_busy, m_addr, m_data, m_cnt});
      end
      if (i == 3) begin
        checks++;
        if ({err, err_code, l_wren, l_addr, l_data} !== {1'b1, 2'b01, 1'b0, 4'h3, 8'h55}) begin
          errors++;
          $display("FAIL bad_checksum err: got %h expected %h",
                   {err, err_code, l_wren, l_addr, l_data}, {1'b1, 2'b01, 1'b0, 4'h3, 8'h55});
        end
      end
      if (i == 4) begin
        checks++;
        if ({err, err_code} !== 3'b000) begin
          errors++;
          $display("FAIL bad_checksum clear: got %b expected 000", {err, err_code});
        end
      end
    end
  endtask

  task automatic test_addr_range();
    logic [8:0] s[$] = '{9'h1A5, 9'h109, 9'h111, 9'h1BD, 9'h000,
                         9'h1A5, 9'h113, 9'h111, 9'h1A7, 9'h000, 9'h000};
    foreach (s[i]) begin
      drive(s[i][8], s[i][7:0]);
      checks++;
      if ({l_wren, err, err_code, busy, l_addr, l_data, good_cnt} !==
          {m_wren, m_err, m_code, m_busy, m_addr, m_data, m_cnt}) begin
        errors++;
        $display("FAIL addr_range model @%0d: got %h expected %h", i,
                 {l_wren, err, err_code, busy, l_addr, l_data, good_cnt},
                 {m_wren, m_err, m_code, m_busy, m_addr, m_data, m_cnt});
      end
      if (i == 3 || i == 8) begin
        checks++;
        if ({err, err_code, l_wren, good_cnt} !== {1'b1, 2'b10, 1'b0, 8'd1}) begin
          errors++;
          $display("FAIL addr_range err @%0d: got %h expected %h", i,
                   {err, err_code, l_wren, good_cnt}, {1'b1, 2'b10, 1'b0, 8'd1});
        end
      end
    end
  endtask

  task automatic test_hunt_b2b();
    logic [8:0] s[$] = '{9'h100, 9'h1FF, 9'h1A5, 9'h100, 9'h17E, 9'h1DB,
                         9'h1A5, 9'h108, 9'h13C, 9'h191, 9'h000, 9'h000};
    foreach (s[i]) begin
      drive(s[i][8], s[i][7:0]);
      checks++;
      if ({l_wren, err, err_code, busy, l_addr, l_data, good_cnt} !==
          {m_wren, m_err, m_code, m_busy, m_addr, m_data, m_cnt}) begin
        errors++;
        $display("FAIL hunt_b2b model @%0d: got %h expected %h", i,
                 {l_wren, err, err_code, busy, l_addr, l_data, good_cnt},
                 {m_wren, m_err, m_code, m_busy, m_addr, m_data, m_cnt});
      end
      if (i == 5) begin
        checks++;
        if ({l_wren, l_addr, l_data, good_cnt} !== {1'b1, 4'h0, 8'h7E, 8'd2}) begin
          errors++;
          $display("FAIL hunt_b2b first: got %h expected %h",
                   {l_wren, l_addr, l_data, good_cnt}, {1'b1, 4'h0, 8'h7E, 8'd2});
        end
      end
      if (i == 9) begin
        checks++;
        if ({l_wren, l_addr, l_data, good_cnt} !== {1'b1, 4'h8, 8'h3C, 8'd3}) begin
          errors++;
          $display("FAIL hunt_b2b second: got %h expected %h",
                   {l_wren, l_addr, l_data, good_cnt}, {1'b1, 4'h8, 8'h3C, 8'd3});
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [8:0] s[$];
    int t_pre, t_fire, t_w1, t_late, t_w2;
    s.push_back(9'h1A5); s.push_back(9'h102);
    repeat (TO - 1) s.push_back(9'h000);
    t_pre = s.size() - 1;
    s.push_back(9'h000);
    t_fire = s.size() - 1;
    s.push_back(9'h000);
    s.push_back(9'h1A5); s.push_back(9'h102); s.push_back(9'h1AA); s.push_back(9'h10D);
    t_w1 = s.size() - 1;
    s.push_back(9'h1A5); s.push_back(9'h102);
    repeat (TO - 1) s.push_back(9'h000);
    s.push_back(9'h1AA);
    t_late = s.size() - 1;
    repeat (TO - 1) s.push_back(9'h000);
    s.push_back(9'h10D);
    t_w2 = s.size() - 1;
    s.push_back(9'h000);
    foreach (s[i]) begin
      drive(s[i][8], s[i][7:0]);
      checks++;
      if ({l_wren, err, err_code, busy, l_addr, l_data, good_cnt} !==
          {m_wren, m_err, m_code, m_busy, m_addr, m_data, m_cnt}) begin
        errors++;
        $display("FAIL timeout model @%0d: got %h expected %h", i,
                 {l_wren, err, err_code, busy, l_addr, l_data, good_cnt},
                 {m_wren, m_err, m_code, m_busy, m_addr, m_data, m_cnt});
      end
      if (i == t_pre || i == t_late) begin
        checks++;
        if ({busy, err} !== 2'b10) begin
          errors++;
          $display("FAIL timeout early @%0d: got busy/err %b expected 10", i, {busy, err});
        end
      end
      if (i == t_fire) begin
        checks++;
        if ({err, err_code, busy} !== 4'b1110) begin
          errors++;
          $display("FAIL timeout fire: got %b expected 1110", {err, err_code, busy});
        end
      end
      if (i == t_fire + 1) begin
        checks++;
        if (err !== 1'b0) begin
          errors++;
          $display("FAIL timeout pulse_width: got %b expected 0", err);
        end
      end
      if (i == t_w1 || i == t_w2) begin
        checks++;
        if ({l_wren, err, l_addr, l_data} !== {1'b1, 1'b0, 4'h2, 8'hAA}) begin
          errors++;
          $display("FAIL timeout write @%0d: got %h expected %h", i,
                   {l_wren, err, l_addr, l_data}, {1'b1, 1'b0, 4'h2, 8'hAA});
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [8:0] s[$] = '{9'h177, 9'h100, 9'h000, 9'h000, 9'h000};
    drive(1'b1, 8'hA5);
    drive(1'b1, 8'h04);
    rstn = 1'b0;
    drive(1'b0, 8'h00);
    rstn = 1'b1;
    checks++;
    if ({l_wren, err, err_code, busy, l_addr, l_data, good_cnt} !== 25'd0) begin
      errors++;
      $display("FAIL reset_midframe zero: got %h expected 0",
               {l_wren, err, err_code, busy, l_addr, l_data, good_cnt});
    end
    foreach (s[i]) begin
      drive(s[i][8], s[i][7:0]);
      checks++;
      if ({l_wren, err, busy, good_cnt} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
        errors++;
        $display("FAIL reset_midframe quiet @%0d: got %h expected 0", i,
                 {l_wren, err, busy, good_cnt});
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] s[$];
    logic [7:0] a, d, c;
    logic [7:0] fb[4];
    int nj, g;
    for (int f = 0; f < 300; f++) begin
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) s.push_back({2'b01, 8'($urandom)});
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      d = 8'($urandom);
      c = 8'hA5 ^ a ^ d;
      if ($urandom_range(0, 4) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
      fb = '{8'hA5, a, d, c};
      for (int k = 0; k < 4; k++) begin
        s.push_back({2'b01, fb[k]});
        if (k == 1 && $urandom_range(0, 49) == 0) s.push_back(10'h200);
        if (k < 3) begin
          g = ($urandom_range(0, 59) == 0) ? (TO - 1 + int'($urandom_range(0, 1)))
                                           : int'($urandom_range(0, 2));
          repeat (g) s.push_back(10'h000);
        end
      end
    end
    foreach (s[i]) begin
      rstn = !s[i][9];
      drive(s[i][8], s[i][7:0]);
      checks++;
      if ({l_wren, err, err_code, busy, l_addr, l_data, good_cnt} !==
          {m_wren, m_err, m_code, m_busy, m_addr, m_data, m_cnt}) begin
        errors++;
        $display("FAIL random model @%0d: got %h expected %h", i,
                 {l_wren, err, err_code, busy, l_addr, l_data, good_cnt},
                 {m_wren, m_err, m_code, m_busy, m_addr, m_data, m_cnt});
      end
      checks++;
      if ((l_wren && err) || (!err && err_code !== 2'b00)) begin
        errors++;
        $display("FAIL random exclusive @%0d: got wren/err/code %b expected no overlap", i,
                 {l_wren, err, err_code});
      end
    end
    rstn = 1'b1;
  endtask

  initial begin
    rstn     = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_addr_range();
    test_hunt_b2b();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
